uart_tx_frame: RTL

// - UART transmitter; the transmit end of the link whose receive path starts with the start-bit glitch checker.
// - Accepts a parallel byte and serialises it onto TX_OUT, one bit per CLK: start, 8 data bits (LSB first), optional parity, stop.
// - CLK is the TX bit clock, already divided down by the system clock divider. Busy back-pressures the sending FIFO/controller.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_serializer.sv | 52 +++++
 rtl/uart_tx_frame.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: transmit FSM state encoding and fixed line levels
// used by the transmitter and its serializer.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Shift register plus bit counter feeding the UART transmit FSM.
//
// Ports
//   clk_i       in   1           TX bit clock
//   rst_ni      in   1           asynchronous active-low reset
//   load_i      in   1           capture data_i, restart the bit counter
//   shift_en_i  in   1           advance to the next data bit
//   data_i      in   DATA_WIDTH  parallel byte to serialise
//   ser_bit_o   out  1           bit the FSM puts on the line at the next edge
//   ser_done_o  out  1           the bit currently on the line is the last one
//
// The FSM registers TX_OUT one edge ahead, so ser_bit_o always presents the
// *next* bit: the register shifts as each bit is handed to the line. The
// counter is preloaded to all-ones so that the first shift (START -> DATA)
// wraps it to 0; while in DATA it then equals the index of the bit on the line.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  shift_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_bit_o,
    output logic                  ser_done_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CW-1:0]         cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= '1;
        end else if (shift_en_i) begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign ser_bit_o  = shreg_q[0];
    assign ser_done_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule : uart_tx_serializer

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: one bit per CLK, frame = start, DATA_WIDTH data bits
// (LSB first), optional parity, stop. Back-to-back frames when Data_Valid is
// present at the stop-bit exit.
//
// Ports
//   CLK         in   1           TX bit clock
//   RST         in   1           asynchronous active-low reset
//   P_DATA      in   DATA_WIDTH  parallel data, sampled when a frame is accepted
//   Data_Valid  in   1           send request (pulse or level)
//   PAR_EN      in   1           insert parity bit (sampled with P_DATA)
//   PAR_TYP     in   1           0 even, 1 odd parity (sampled with P_DATA)
//   TX_OUT      out  1           serial line, idles high, registered
//   Busy        out  1           high for every cycle of a frame, registered
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             state_q, state_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;

    logic                  load;
    logic                  shift_en;
    logic                  ser_bit;
    logic                  ser_done;
    logic                  par_bit;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (load),
        .shift_en_i (shift_en),
        .data_i     (P_DATA),
        .ser_bit_o  (ser_bit),
        .ser_done_o (ser_done)
    );

    // Parity always comes from the byte captured at accept time.
    assign par_bit = (par_typ_q == PAR_ODD) ? ~^data_q : ^data_q;

    // Outputs are registered from the next-state decision, so every line
    // level appears at the same edge that enters the corresponding state.
    always_comb begin
        state_d  = state_q;
        tx_out_d = IDLE_LEVEL;
        busy_d   = 1'b1;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Data_Valid) begin
                    load     = 1'b1;
                    state_d  = START;
                    tx_out_d = START_BIT;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d  = DATA;
                tx_out_d = ser_bit;
                shift_en = 1'b1;
            end
            DATA: begin
                if (!ser_done) begin
                    tx_out_d = ser_bit;
                    shift_en = 1'b1;
                end else if (par_en_q) begin
                    state_d  = PARITY;
                    tx_out_d = par_bit;
                end else begin
                    state_d  = STOP;
                    tx_out_d = STOP_BIT;
                end
            end
            PARITY: begin
                state_d  = STOP;
                tx_out_d = STOP_BIT;
            end
            STOP: begin
                if (Data_Valid) begin
                    load     = 1'b1;
                    state_d  = START;
                    tx_out_d = START_BIT;
                end else begin
                    state_d  = IDLE;
                    tx_out_d = IDLE_LEVEL;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tx_out_q  <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            state_q  <= state_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            if (load) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule : uart_tx_frame
